code_lock_ctrl: RTL and testbench

//  Parametrised successor to the two-button code-entry controller. It debounces the raw

---
 rtl/code_lock_ctrl_if.sv | 34 +++
 rtl/code_lock_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_code_lock_ctrl.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/code_lock_ctrl_if.sv
// Button/status bundle for the code lock controller.
// master: drives the raw buttons and mode switch, observes the status.
// slave : the controller; samples the buttons, drives the status.
//   enter0, enter1, confirm, clear, mode : raw push-buttons / switch (master -> slave)
//   led      : entry buffer, newest bit at LSB         (slave -> master)
//   cnt      : number of bits entered so far           (slave -> master)
//   unlocked, fail, locked_out, prog : state flags     (slave -> master)
interface code_lock_ctrl_if #(
    parameter int unsigned CODE_LEN = 6
);
    localparam int unsigned CNT_W = $clog2(CODE_LEN + 1);

    logic                enter0;
    logic                enter1;
    logic                confirm;
    logic                clear;
    logic                mode;
    logic [CODE_LEN-1:0] led;
    logic [CNT_W-1:0]    cnt;
    logic                unlocked;
    logic                fail;
    logic                locked_out;
    logic                prog;

    modport master (
        output enter0, enter1, confirm, clear, mode,
        input  led, cnt, unlocked, fail, locked_out, prog
    );

    modport slave (
        input  enter0, enter1, confirm, clear, mode,
        output led, cnt, unlocked, fail, locked_out, prog
    );
endinterface

// File: rtl/code_lock_ctrl.sv
// Code-entry lock controller. Debounces five raw inputs, shifts a CODE_LEN-bit code in,
// compares it against a stored key on confirm, counts consecutive failures with a timed
// lockout, and lets the key be reprogrammed while unlocked.
// Ports:
//   clock   : single rising-edge clock
//   reset_n : synchronous active-low reset (key reverts to KEY)
//   bus     : code_lock_ctrl_if.slave -- raw buttons in, registered status out
module code_lock_ctrl #(
    parameter int unsigned         FRE         = 25000000,
    parameter int unsigned         DEBOUNCE_MS = 10,
    parameter int unsigned         CODE_LEN    = 6,
    parameter logic [CODE_LEN-1:0] KEY         = 6'b101101,
    parameter int unsigned         MAX_FAIL    = 3,
    parameter int unsigned         LOCKOUT_S   = 5
) (
    input logic             clock,
    input logic             reset_n,
    code_lock_ctrl_if.slave bus
);
    localparam int unsigned DB_CYC   = FRE / 1000 * DEBOUNCE_MS;
    localparam int unsigned LOCK_CYC = FRE * LOCKOUT_S;
    localparam int unsigned DB_W     = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
    localparam int unsigned LOCK_W   = (LOCK_CYC > 1) ? $clog2(LOCK_CYC) : 1;
    localparam int unsigned CNT_W    = $clog2(CODE_LEN + 1);
    localparam int unsigned FAIL_W   = $clog2(MAX_FAIL + 1);
    localparam int unsigned NB       = 5;

    typedef enum logic [2:0] {
        StIdle, StEntry, StCheck, StOpen, StProg, StFail, StLockout
    } state_e;

    // ---------------- debouncers: bit 0 enter0, 1 enter1, 2 confirm, 3 clear, 4 mode
    logic [NB-1:0]   raw, sync1_q, sync2_q, stable_q;
    logic [3:0]      prev_q;
    logic [DB_W-1:0] db_cnt_q [NB];
    logic [3:0]      press;

    assign raw = {bus.mode, bus.clear, bus.confirm, bus.enter1, bus.enter0};

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            prev_q   <= '0;
            for (int i = 0; i < NB; i++) db_cnt_q[i] <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            prev_q  <= stable_q[3:0];
            for (int i = 0; i < NB; i++) begin
                // Any cycle agreeing with the stable level restarts the count.
                if (sync2_q[i] == stable_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == DB_W'(DB_CYC - 1)) begin
                    stable_q[i] <= sync2_q[i];
                    db_cnt_q[i] <= '0;
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    assign press = stable_q[3:0] & ~prev_q;

    // Priority clear > confirm > enter; both enters at once cancel each other.
    logic do_clr, do_conf, do_enter, enter_bit, mode_lvl;
    assign do_clr    = press[3];
    assign do_conf   = !press[3] && press[2];
    assign do_enter  = !press[3] && !press[2] && (press[0] ^ press[1]);
    assign enter_bit = press[1];
    assign mode_lvl  = stable_q[4];

    // ---------------- state / datapath registers
    state_e              state_q, state_d;
    logic [CODE_LEN-1:0] buf_q, buf_d, key_q, key_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [FAIL_W-1:0]   fail_cnt_q, fail_cnt_d;
    logic [LOCK_W-1:0]   lock_cnt_q, lock_cnt_d;
    logic [CODE_LEN-1:0] led_q, led_d;
    logic [CNT_W-1:0]    cnt_out_q, cnt_out_d;
    logic                unlocked_q, unlocked_d, fail_q, fail_d;
    logic                locked_out_q, locked_out_d, prog_q, prog_d;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            buf_q        <= '0;
            cnt_q        <= '0;
            key_q        <= KEY;
            fail_cnt_q   <= '0;
            lock_cnt_q   <= '0;
            led_q        <= '0;
            cnt_out_q    <= '0;
            unlocked_q   <= 1'b0;
            fail_q       <= 1'b0;
            locked_out_q <= 1'b0;
            prog_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            buf_q        <= buf_d;
            cnt_q        <= cnt_d;
            key_q        <= key_d;
            fail_cnt_q   <= fail_cnt_d;
            lock_cnt_q   <= lock_cnt_d;
            led_q        <= led_d;
            cnt_out_q    <= cnt_out_d;
            unlocked_q   <= unlocked_d;
            fail_q       <= fail_d;
            locked_out_q <= locked_out_d;
            prog_q       <= prog_d;
        end
    end

    // ---------------- next-state logic
    logic                full;
    logic [CODE_LEN-1:0] shifted, first;
    assign full    = (cnt_q == CNT_W'(CODE_LEN));
    assign shifted = {buf_q[CODE_LEN-2:0], enter_bit};
    assign first   = CODE_LEN'(enter_bit);

    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        cnt_d      = cnt_q;
        key_d      = key_q;
        fail_cnt_d = fail_cnt_q;
        lock_cnt_d = lock_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (do_enter) begin
                    buf_d   = first;
                    cnt_d   = CNT_W'(1);
                    state_d = StEntry;
                end
            end
            StEntry, StProg: begin
                if (do_clr) begin
                    buf_d   = '0;
                    cnt_d   = '0;
                    state_d = (state_q == StProg) ? StOpen : StIdle;
                end else if (do_conf && full) begin
                    if (state_q == StProg) begin
                        key_d   = buf_q;
                        buf_d   = '0;
                        cnt_d   = '0;
                        state_d = StIdle;
                    end else begin
                        state_d = StCheck;
                    end
                end else if (do_enter && !full) begin
                    buf_d = shifted;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StCheck: begin
                if (buf_q == key_q) begin
                    fail_cnt_d = '0;
                    state_d    = StOpen;
                end else begin
                    fail_cnt_d = fail_cnt_q + FAIL_W'(1);
                    if (fail_cnt_q == FAIL_W'(MAX_FAIL - 1)) begin
                        lock_cnt_d = '0;
                        state_d    = StLockout;
                    end else begin
                        state_d = StFail;
                    end
                end
            end
            StOpen: begin
                if (do_clr) begin
                    buf_d   = '0;
                    cnt_d   = '0;
                    state_d = StIdle;
                end else if (do_enter && mode_lvl) begin
                    buf_d   = first;
                    cnt_d   = CNT_W'(1);
                    state_d = StProg;
                end
            end
            StFail: begin
                if (do_clr) begin
                    buf_d   = '0;
                    cnt_d   = '0;
                    state_d = StIdle;
                end
            end
            StLockout: begin
                if (lock_cnt_q == LOCK_W'(LOCK_CYC - 1)) begin
                    fail_cnt_d = '0;
                    buf_d      = '0;
                    cnt_d      = '0;
                    state_d    = StIdle;
                end else begin
                    lock_cnt_d = lock_cnt_q + LOCK_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // ---------------- output decode (registered above)
    always_comb begin
        led_d        = buf_q;
        cnt_out_d    = cnt_q;
        unlocked_d   = (state_q == StOpen) || (state_q == StProg);
        fail_d       = (state_q == StFail);
        locked_out_d = (state_q == StLockout);
        prog_d       = (state_q == StProg);
    end

    assign bus.led        = led_q;
    assign bus.cnt        = cnt_out_q;
    assign bus.unlocked   = unlocked_q;
    assign bus.fail       = fail_q;
    assign bus.locked_out = locked_out_q;
    assign bus.prog       = prog_q;
endmodule

// File: tb/tb_code_lock_ctrl.sv
// Bench for code_lock_ctrl: directed scenarios followed by random button presses, each
// press checked against an event-level behavioural model of the lock.
module tb_code_lock_ctrl;
    localparam int unsigned FRE         = 1000;
    localparam int unsigned DEBOUNCE_MS = 4;
    localparam int unsigned CODE_LEN    = 6;
    localparam int unsigned MAX_FAIL    = 3;
    localparam int unsigned LOCKOUT_S   = 1;
    localparam int          LOCK_CYC    = 1000;
    localparam logic [5:0]  KEY         = 6'b101101;
    localparam int          HOLD        = 8;
    localparam int          B_E0 = 1, B_E1 = 2, B_CONF = 4, B_CLR = 8;
    localparam int          M_IDLE = 0, M_ENTRY = 1, M_OPEN = 2, M_PROG = 3,
                            M_FAIL = 4, M_LOCK = 5;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    code_lock_ctrl_if #(.CODE_LEN(CODE_LEN)) bus ();

    code_lock_ctrl #(
        .FRE(FRE), .DEBOUNCE_MS(DEBOUNCE_MS), .CODE_LEN(CODE_LEN), .KEY(KEY),
        .MAX_FAIL(MAX_FAIL), .LOCKOUT_S(LOCKOUT_S)
    ) dut (
        .clock(clock), .reset_n(reset_n), .bus(bus)
    );

    int n_chk = 0, n_pass = 0, n_fail = 0;
    int m_st, m_buf, m_cnt, m_key, m_fails;
    bit m_mode;
    int lo_run = 0, lo_last = 0;

    // Length of the most recent locked_out pulse, in cycles.
    always @(posedge clock) begin
        if (!reset_n) lo_run <= 0;
        else if (bus.locked_out) lo_run <= lo_run + 1;
        else if (lo_run != 0) begin
            lo_last <= lo_run;
            lo_run  <= 0;
        end
    end

    task automatic chk(input string tag, input string what, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s %s: observed %0h expected %0h", tag, what, got, exp);
        end
    endtask

    task automatic model_reset();
        m_st = M_IDLE; m_buf = 0; m_cnt = 0; m_fails = 0; m_key = KEY;
    endtask

    // One debounced press event (mask of buttons pressed together).
    task automatic model_event(input int m);
        int b;
        if (m_st == M_LOCK) return;
        if ((m & B_CLR) != 0) begin
            if (m_st == M_PROG) begin m_st = M_OPEN; m_buf = 0; m_cnt = 0; end
            else if (m_st != M_IDLE) begin m_st = M_IDLE; m_buf = 0; m_cnt = 0; end
        end else if ((m & B_CONF) != 0) begin
            if (m_cnt == CODE_LEN && m_st == M_ENTRY) begin
                if (m_buf == m_key) begin m_st = M_OPEN; m_fails = 0; end
                else begin
                    m_fails++;
                    m_st = (m_fails == MAX_FAIL) ? M_LOCK : M_FAIL;
                end
            end else if (m_cnt == CODE_LEN && m_st == M_PROG) begin
                m_key = m_buf; m_buf = 0; m_cnt = 0; m_st = M_IDLE;
            end
        end else if (((m & B_E0) != 0) != ((m & B_E1) != 0)) begin
            b = ((m & B_E1) != 0) ? 1 : 0;
            case (m_st)
                M_IDLE: begin m_buf = b; m_cnt = 1; m_st = M_ENTRY; end
                M_ENTRY, M_PROG: if (m_cnt < CODE_LEN) begin
                    m_buf = ((m_buf * 2) + b) % (1 << CODE_LEN);
                    m_cnt++;
                end
                M_OPEN: if (m_mode) begin m_st = M_PROG; m_buf = b; m_cnt = 1; end
                default: ;
            endcase
        end
    endtask

    task automatic check_all(input string tag);
        chk(tag, "led", bus.led, m_buf);
        chk(tag, "cnt", bus.cnt, m_cnt);
        chk(tag, "unlocked", bus.unlocked, (m_st == M_OPEN || m_st == M_PROG) ? 1 : 0);
        chk(tag, "fail", bus.fail, (m_st == M_FAIL) ? 1 : 0);
        chk(tag, "locked_out", bus.locked_out, (m_st == M_LOCK) ? 1 : 0);
        chk(tag, "prog", bus.prog, (m_st == M_PROG) ? 1 : 0);
    endtask

    task automatic drive(input int m);
        bus.enter0  = (m & B_E0) != 0;
        bus.enter1  = (m & B_E1) != 0;
        bus.confirm = (m & B_CONF) != 0;
        bus.clear   = (m & B_CLR) != 0;
    endtask

    task automatic press(input int m, input string tag);
        @(negedge clock);
        drive(m);
        repeat (HOLD) @(negedge clock);
        drive(0);
        repeat (HOLD) @(negedge clock);
        model_event(m);
        check_all(tag);
    endtask

    task automatic enter_code(input logic [5:0] c, input string tag);
        for (int i = CODE_LEN - 1; i >= 0; i--) press(c[i] ? B_E1 : B_E0, tag);
    endtask

    task automatic set_mode(input bit v);
        @(negedge clock);
        bus.mode = v;
        m_mode = v;
        repeat (10) @(negedge clock);
    endtask

    task automatic wait_lock_exit(input string tag);
        int k = 0;
        while (bus.locked_out && k < 1500) begin
            @(negedge clock);
            k++;
        end
        chk(tag, "lockout_ends", bus.locked_out, 0);
        repeat (3) @(negedge clock);
        if (m_st == M_LOCK) begin
            m_st = M_IDLE; m_fails = 0; m_buf = 0; m_cnt = 0;
        end
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clock);
        reset_n = 1'b0;
        drive(0);
        bus.mode = 1'b0;
        m_mode = 1'b0;
        repeat (3) @(negedge clock);
        model_reset();
        check_all(tag);
        reset_n = 1'b1;
        repeat (10) @(negedge clock);
    endtask

    initial begin
        int r, bitv;
        drive(0);
        bus.mode = 1'b0;
        m_mode = 1'b0;
        model_reset();
        repeat (4) @(negedge clock);
        check_all("reset");
        reset_n = 1'b1;
        repeat (10) @(negedge clock);

        // 1: correct code unlocks
        enter_code(6'b101101, "t1_entry");
        press(B_CONF, "t1_confirm");
        chk("t1", "led_const", bus.led, 6'b101101);
        chk("t1", "unlocked_const", bus.unlocked, 1);
        press(B_CLR, "t1_relock");

        // 2: three failures -> lockout, presses ignored, then idle
        for (int a = 0; a < 3; a++) begin
            enter_code(6'b000000, "t2_entry");
            press(B_CONF, "t2_confirm");
            if (a < 2) begin
                chk("t2", "fail_const", bus.fail, 1);
                press(B_CLR, "t2_ack");
            end
        end
        chk("t2", "locked_const", bus.locked_out, 1);
        press(B_CLR, "t2_lock_clr");
        press(B_E1, "t2_lock_e1");
        press(B_CONF, "t2_lock_conf");
        wait_lock_exit("t2_exit");
        chk("t2", "lock_cycles", lo_last, LOCK_CYC);
        chk("t2", "led_zero", bus.led, 0);

        // 3: glitch rejected, bounce yields one bit
        @(negedge clock);
        bus.enter1 = 1'b1;
        repeat (2) @(negedge clock);
        bus.enter1 = 1'b0;
        repeat (16) @(negedge clock);
        check_all("t3_glitch");
        bus.enter1 = 1'b1; @(negedge clock);
        bus.enter1 = 1'b0; @(negedge clock);
        bus.enter1 = 1'b1;
        repeat (HOLD) @(negedge clock);
        bus.enter1 = 1'b0;
        repeat (HOLD) @(negedge clock);
        model_event(B_E1);
        check_all("t3_bounce");
        chk("t3", "cnt_one", bus.cnt, 1);
        press(B_CLR, "t3_clr");

        // 4: reprogram key
        enter_code(6'b101101, "t4_open");
        press(B_CONF, "t4_open_conf");
        set_mode(1'b1);
        enter_code(6'b000111, "t4_prog");
        press(B_CONF, "t4_prog_conf");
        chk("t4", "relocked", bus.unlocked, 0);
        set_mode(1'b0);
        enter_code(6'b000111, "t4_new");
        press(B_CONF, "t4_new_conf");
        chk("t4", "new_key_opens", bus.unlocked, 1);
        press(B_CLR, "t4_clr");
        enter_code(6'b101101, "t4_old");
        press(B_CONF, "t4_old_conf");
        chk("t4", "old_key_fails", bus.fail, 1);
        press(B_CLR, "t4_ack");

        // 5: boundaries
        for (int i = 0; i < 5; i++) press(B_E1, "t5_five");
        press(B_CONF, "t5_short_conf");
        chk("t5", "cnt_five", bus.cnt, 5);
        press(B_E0, "t5_sixth");
        press(B_E1, "t5_seventh");
        chk("t5", "cnt_six", bus.cnt, 6);
        press(B_CLR | B_CONF, "t5_clr_conf");
        press(B_E0 | B_E1, "t5_both_enter");

        // 6: resets
        enter_code(6'b000111, "t6_pre");
        press(B_CONF, "t6_pre_conf");
        press(B_CLR, "t6_pre_clr");
        press(B_E1, "t6_mid1");
        press(B_E0, "t6_mid2");
        do_reset("t6_mid_entry");
        enter_code(6'b101101, "t6_key_back");
        press(B_CONF, "t6_key_back_conf");
        chk("t6", "key_reverted", bus.unlocked, 1);
        press(B_CLR, "t6_clr");
        for (int a = 0; a < 3; a++) begin
            enter_code(6'b111111, "t6_bad");
            press(B_CONF, "t6_bad_conf");
            if (a < 2) press(B_CLR, "t6_bad_ack");
        end
        repeat (100) @(negedge clock);
        do_reset("t6_mid_lock");
        enter_code(6'b101101, "t6_after");
        press(B_CONF, "t6_after_conf");
        press(B_CLR, "t6_after_clr");

        // random presses against the model
        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 9);
            if (r <= 5) begin
                if ($urandom_range(0, 1) == 1 && m_cnt < CODE_LEN)
                    bitv = (m_key >> (CODE_LEN - 1 - m_cnt)) & 1;
                else
                    bitv = $urandom_range(0, 1);
                press((bitv != 0) ? B_E1 : B_E0, "rand_enter");
            end else if (r <= 7) begin
                press(B_CONF, "rand_conf");
            end else if (r == 8) begin
                press(B_CLR, "rand_clr");
            end else begin
                set_mode(!m_mode);
                check_all("rand_mode");
            end
            if (m_st == M_LOCK) wait_lock_exit("rand_lock");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
